serial_ripple_borrow_subtractor: RTL and testbench

- Parameterized multi-cycle subtractor computing Diff = A - B - Bin with a ripple-borrow chain of CHUNK full-subtractor cells.
- Processes CHUNK bits per clock, LSB chunk first, so a full operation takes N/CHUNK cycles.
- Uses valid/ready handshakes on input and output.
- It is the subtract counterpart of the team's ripple carry adder and is used where the area of an N-bit combinational chain is not justified.

---
 rtl/serial_ripple_borrow_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_ripple_borrow_subtractor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_borrow_subtractor.sv
// Multi-cycle A - B - Bin: CHUNK full-subtractor cells per clock,
// LSB chunk first, borrow carried between cycles in a register.
module serial_ripple_borrow_subtractor #(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         Ovf,
    output logic         busy
);

    localparam int STEPS = N / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [N-1:0]       sa;
    logic [N-1:0]       sb;
    logic [N-1:0]       acc;
    logic               br;
    logic [CW-1:0]      cnt;
    logic [CHUNK-1:0]   cd;
    logic               cbo;
    logic               cbi_top;
    logic               last;
    logic [N+CHUNK-1:0] cat;
    logic [N-1:0]       acc_n;

    // Ripple chain over the low chunk; cbi_top is the borrow into its MSB cell
    always_comb begin
        logic b;
        b       = br;
        cbi_top = br;
        cd      = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cbi_top = b;
            cd[i]   = sa[i] ^ sb[i] ^ b;
            b       = (~sa[i] & sb[i]) | (~(sa[i] ^ sb[i]) & b);
        end
        cbo = b;
    end

    assign last  = (cnt == LAST);
    assign cat   = {cd, acc};
    assign acc_n = cat[N+CHUNK-1:CHUNK];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            acc  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            Diff <= '0;
            Bout <= 1'b0;
            Ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa  <= A;
                        sb  <= B;
                        br  <= Bin;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> CHUNK;
                    sb  <= sb >> CHUNK;
                    acc <= acc_n;
                    br  <= cbo;
                    cnt <= cnt + 1'b1;
                    // Final chunk holds bit N-1, so its borrows give Bout/Ovf
                    if (last) begin
                        Diff <= acc_n;
                        Bout <= cbo;
                        Ovf  <= cbi_top ^ cbo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Bench for serial_ripple_borrow_subtractor: directed cases on CHUNK=2
// and a random sweep over CHUNK = 1, 2, 4, 8 with N = 8.
module tb_serial_ripple_borrow_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] iv  = 4'h0;
    logic       out_ready = 1'b1;
    logic [7:0] A   = 8'h00;
    logic [7:0] B   = 8'h00;
    logic       Bin = 1'b0;
    logic [3:0] ir;
    logic [3:0] ov;
    logic [3:0] bz;
    logic [3:0] bo;
    logic [3:0] of;
    logic [7:0] df [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_ripple_borrow_subtractor #(
            .N    (8),
            .CHUNK(1 << g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .A        (A),
            .B        (B),
            .Bin      (Bin),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .Diff     (df[g]),
            .Bout     (bo[g]),
            .Ovf      (of[g]),
            .busy     (bz[g])
        );
    end

    // {ovf, bout, diff} from plain integer arithmetic
    function automatic logic [9:0] ref_sub(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       bin
    );
        logic [8:0] r;
        int s;
        r = {1'b0, a} - {1'b0, b} - {8'h00, bin};
        s = int'($signed(a)) - int'($signed(b)) - (bin ? 1 : 0);
        return {(s < -128 || s > 127), r[8], r[7:0]};
    endfunction

    task automatic do_op(
        input  int         k,
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  logic       bin,
        output int         lat,
        output logic [7:0] d,
        output logic       bout,
        output logic       ovf
    );
        A = a;
        B = b;
        Bin = bin;
        iv[k] = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat <= 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d = df[k];
        bout = bo[k];
        ovf = of[k];
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ir !== 4'hF) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1111", ir);
        end
        checks++;
        if ({ov, bz, bo, of} !== 16'h0) begin
            errors++;
            $display("FAIL reset_flags: got ov=%b bz=%b bo=%b of=%b want 0",
                     ov, bz, bo, of);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (df[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_diff[%0d]: got %h want 00", k, df[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] ta [5] = '{8'h50, 8'h00, 8'h80, 8'h7F, 8'h10};
        logic [7:0] tb [5] = '{8'h30, 8'h01, 8'h01, 8'hFF, 8'h0F};
        logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ed [5] = '{8'h20, 8'hFF, 8'h7F, 8'h80, 8'h00};
        logic       eb [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        logic [7:0] d;
        logic bout;
        logic ovf;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op(1, ta[i], tb[i], tc[i], lat, d, bout, ovf);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if ({d, bout, ovf} !== {ed[i], eb[i], eo[i]}) begin
                errors++;
                $display("FAIL dir%0d_result: got d=%h b=%b o=%b want d=%h b=%b o=%b",
                         i, d, bout, ovf, ed[i], eb[i], eo[i]);
            end
            checks++;
            if (ir[1] !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_ready_after: got %b want 1", i, ir[1]);
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        A = 8'h5A;
        B = 8'h13;
        Bin = 1'b0;
        iv[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bz[1] !== 1'b1 || ir[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_busy: got busy=%b in_ready=%b want 1 0", bz[1], ir[1]);
        end
        for (int i = 0; i < 4; i++) begin
            iv[1] = (i % 2 == 0);
            A = 8'hFF;
            B = 8'h00;
            @(posedge clk);
            #1;
        end
        checks++;
        if (ov[1] !== 1'b1 || df[1] !== 8'h47) begin
            errors++;
            $display("FAIL bp_done: got ov=%b d=%h want 1 47", ov[1], df[1]);
        end
        for (int i = 0; i < 3; i++) begin
            iv[1] = ~iv[1];
            A = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({ov[1], ir[1], df[1], bo[1], of[1]} !== {1'b1, 1'b0, 8'h47, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got ov=%b ir=%b d=%h b=%b o=%b want 1 0 47 0 0",
                         i, ov[1], ir[1], df[1], bo[1], of[1]);
            end
        end
        iv[1] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff: got ov=%b ir=%b want 0 1", ov[1], ir[1]);
        end
    endtask

    task automatic test_abort;
        int lat;
        logic [7:0] d;
        logic bout;
        logic ovf;
        out_ready = 1'b1;
        A = 8'h77;
        B = 8'h11;
        Bin = 1'b0;
        iv[1] = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ov[1], df[1], ir[1], bz[1]} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_state: got ov=%b d=%h ir=%b bz=%b want 0 00 1 0",
                     ov[1], df[1], ir[1], bz[1]);
        end
        do_op(1, 8'h05, 8'h03, 1'b0, lat, d, bout, ovf);
        checks++;
        if (lat !== 4 || {d, bout, ovf} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_fresh: got lat=%0d d=%h b=%b o=%b want 4 02 0 0",
                     lat, d, bout, ovf);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [9:0] exp;
        logic [9:0] got [4];
        int         lat [4];
        logic [3:0] seen;
        int         cyc;
        out_ready = 1'b1;
        for (int v = 0; v < 500; v++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            bin = 1'($urandom);
            if (v < 4) b = a;
            exp = ref_sub(a, b, bin);
            A = a;
            B = b;
            Bin = bin;
            iv = 4'hF;
            @(posedge clk);
            #1;
            iv = 4'h0;
            seen = 4'h0;
            cyc = 0;
            for (int k = 0; k < 4; k++) begin
                lat[k] = 0;
                got[k] = '0;
            end
            while (seen != 4'hF && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
                for (int k = 0; k < 4; k++) begin
                    if (!seen[k] && ov[k]) begin
                        seen[k] = 1'b1;
                        got[k] = {of[k], bo[k], df[k]};
                        lat[k] = cyc;
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== exp) begin
                    errors++;
                    $display("FAIL sweep_c%0d_v%0d: a=%h b=%h bin=%b got o,b,d=%h want %h",
                             1 << k, v, a, b, bin, got[k], exp);
                end
                checks++;
                if (lat[k] !== (8 >> k)) begin
                    errors++;
                    $display("FAIL sweep_lat_c%0d_v%0d: got %0d want %0d",
                             1 << k, v, lat[k], 8 >> k);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
